// File: rtl/conv_window_3x3_pkg.sv
// Shared constants for the 3x3 window generator and convolution core.
// Tap numbering: row-major, top-left = 0, newest pixel = 8.
package conv_window_3x3_pkg;

  localparam int KERNEL_DIM     = 3;
  localparam int KERNEL_TAPS    = KERNEL_DIM * KERNEL_DIM;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int TAP_NEWEST     = KERNEL_TAPS - 1;

  function automatic int tap_idx(input int row, input int col);
    return row * KERNEL_DIM + col;
  endfunction

endpackage

// File: rtl/conv_window_3x3_line_buffer.sv
// One image row of delay: async read of the old word, write at the same
// address on the clock edge, so a read always sees the previous row.
module line_buffer_row
  import conv_window_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 28,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: two row buffers plus a 3x3 shift
// window; emits only fully populated neighbourhoods.
module conv_window_3x3
  import conv_window_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDTH-1:0] Data_Out0,
  output logic [DATA_WIDTH-1:0] Data_Out1,
  output logic [DATA_WIDTH-1:0] Data_Out2,
  output logic [DATA_WIDTH-1:0] Data_Out3,
  output logic [DATA_WIDTH-1:0] Data_Out4,
  output logic [DATA_WIDTH-1:0] Data_Out5,
  output logic [DATA_WIDTH-1:0] Data_Out6,
  output logic [DATA_WIDTH-1:0] Data_Out7,
  output logic [DATA_WIDTH-1:0] Data_Out8,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KL = KERNEL_DIM - 1;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_valid;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_win [KERNEL_DIM][KERNEL_DIM];
  logic [DATA_WIDTH-1:0] w_nxt [KERNEL_DIM][KERNEL_DIM];
  logic [DATA_WIDTH-1:0] w_taps [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0] w_top;
  logic [DATA_WIDTH-1:0] w_mid;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_emit;

  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_emit     = Valid_In && (r_row >= RW'(2)) && (r_col >= CW'(2));

  line_buffer_row #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_W),
    .AW        (CW)
  ) u_lb0 (
    .clk    (clk),
    .i_we   (Valid_In),
    .i_addr (r_col),
    .i_wdata(Data_In),
    .o_rdata(w_mid)
  );

  line_buffer_row #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_W),
    .AW        (CW)
  ) u_lb1 (
    .clk    (clk),
    .i_we   (Valid_In),
    .i_addr (r_col),
    .i_wdata(w_mid),
    .o_rdata(w_top)
  );

  always_comb begin
    for (int r = 0; r < KERNEL_DIM; r++) begin
      for (int c = 0; c < KL; c++) begin
        w_nxt[r][c] = r_win[r][c+1];
      end
    end
    w_nxt[0][KL] = w_top;
    w_nxt[1][KL] = w_mid;
    w_nxt[2][KL] = Data_In;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_valid <= w_emit;
      r_done  <= w_emit && w_last_row && w_last_col;
      if (Valid_In) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        for (int r = 0; r < KERNEL_DIM; r++) begin
          for (int c = 0; c < KERNEL_DIM; c++) begin
            r_win[r][c] <= w_nxt[r][c];
          end
        end
      end
    end
  end

  for (genvar gr = 0; gr < KERNEL_DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < KERNEL_DIM; gc++) begin : g_col
      assign w_taps[tap_idx(gr, gc)] = r_win[gr][gc];
    end
  end

  assign Data_Out0  = w_taps[0];
  assign Data_Out1  = w_taps[1];
  assign Data_Out2  = w_taps[2];
  assign Data_Out3  = w_taps[3];
  assign Data_Out4  = w_taps[4];
  assign Data_Out5  = w_taps[5];
  assign Data_Out6  = w_taps[6];
  assign Data_Out7  = w_taps[7];
  assign Data_Out8  = w_taps[TAP_NEWEST];
  assign Valid_Out  = r_valid;
  assign Frame_Done = r_done;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3 on 4x4, 3x3 and 28x28 frames.
// Expected windows come from a full-frame image model, not line buffers.
module tb_conv_window_3x3;

  localparam int DW = 32;
  localparam int WV = 9 * DW;

  typedef struct packed {
    logic [WV-1:0] win;
    logic          fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [DW-1:0] d4 = '0, d3 = '0, d28 = '0;
  logic          v4 = 1'b0, v3 = 1'b0, v28 = 1'b0;
  logic [DW-1:0] o4 [9];
  logic [DW-1:0] o3 [9];
  logic [DW-1:0] o28 [9];
  logic          ov4, ov3, ov28, fd4, fd3, fd28;

  wire [WV-1:0] w4  = {o4[0], o4[1], o4[2], o4[3], o4[4],
                       o4[5], o4[6], o4[7], o4[8]};
  wire [WV-1:0] w3  = {o3[0], o3[1], o3[2], o3[3], o3[4],
                       o3[5], o3[6], o3[7], o3[8]};
  wire [WV-1:0] w28 = {o28[0], o28[1], o28[2], o28[3], o28[4],
                       o28[5], o28[6], o28[7], o28[8]};

  int n_assert = 0;
  int n_fail   = 0;

  exp_t          q [$];
  int            mr, mc;
  logic [DW-1:0] img [0:27][0:27];

  always #5 clk = ~clk;

  conv_window_3x3 #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .Data_In(d4), .Valid_In(v4),
    .Data_Out0(o4[0]), .Data_Out1(o4[1]), .Data_Out2(o4[2]),
    .Data_Out3(o4[3]), .Data_Out4(o4[4]), .Data_Out5(o4[5]),
    .Data_Out6(o4[6]), .Data_Out7(o4[7]), .Data_Out8(o4[8]),
    .Valid_Out(ov4), .Frame_Done(fd4)
  );

  conv_window_3x3 #(.DATA_WIDTH(DW), .IMG_W(3), .IMG_H(3)) u3 (
    .clk(clk), .rst(rst), .Data_In(d3), .Valid_In(v3),
    .Data_Out0(o3[0]), .Data_Out1(o3[1]), .Data_Out2(o3[2]),
    .Data_Out3(o3[3]), .Data_Out4(o3[4]), .Data_Out5(o3[5]),
    .Data_Out6(o3[6]), .Data_Out7(o3[7]), .Data_Out8(o3[8]),
    .Valid_Out(ov3), .Frame_Done(fd3)
  );

  conv_window_3x3 #(.DATA_WIDTH(DW), .IMG_W(28), .IMG_H(28)) u28 (
    .clk(clk), .rst(rst), .Data_In(d28), .Valid_In(v28),
    .Data_Out0(o28[0]), .Data_Out1(o28[1]), .Data_Out2(o28[2]),
    .Data_Out3(o28[3]), .Data_Out4(o28[4]), .Data_Out5(o28[5]),
    .Data_Out6(o28[6]), .Data_Out7(o28[7]), .Data_Out8(o28[8]),
    .Valid_Out(ov28), .Frame_Done(fd28)
  );

  // Raster model: stores the pixel, returns the window it completes.
  task automatic model_pix(input int w, input int h, input logic [DW-1:0] p,
                           output bit v, output exp_t e);
    img[mr][mc] = p;
    v = (mr >= 2) && (mc >= 2);
    e.fd = (mr == h - 1) && (mc == w - 1);
    e.win = '0;
    if (v) begin
      e.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
               img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
               img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
    end
    if (mc == w - 1) begin
      mc = 0;
      mr = (mr == h - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  function automatic logic [WV-1:0] pack9(input int a0, a1, a2, a3, a4,
                                          a5, a6, a7, a8);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4),
            DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({w4, ov4, fd4} !== '0) begin
      n_fail++;
      $display("FAIL reset_u4: got %h want 0", {w4, ov4, fd4});
    end
    n_assert++;
    if ({w3, ov3, fd3} !== '0) begin
      n_fail++;
      $display("FAIL reset_u3: got %h want 0", {w3, ov3, fd3});
    end
    n_assert++;
    if ({w28, ov28, fd28} !== '0) begin
      n_fail++;
      $display("FAIL reset_u28: got %h want 0", {w28, ov28, fd28});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_continuous();
    exp_t e, g;
    bit   ev;
    int   nw = 0;
    int   nfd = 0;
    q.delete();
    mr = 0;
    mc = 0;
    for (int i = 0; i < 16; i++) begin
      model_pix(4, 4, DW'(i + 1), ev, e);
      if (ev) q.push_back(e);
      d4 = DW'(i + 1);
      v4 = 1'b1;
      @(posedge clk);
      #1;
      v4 = 1'b0;
      n_assert++;
      if (ov4 !== ev) begin
        n_fail++;
        $display("FAIL cont_valid px%0d: got %b want %b", i + 1, ov4, ev);
      end
      if (ov4 === 1'b1 && q.size() > 0) begin
        g = q.pop_front();
        nw++;
        if (fd4 === 1'b1) nfd++;
        n_assert++;
        if ({w4, fd4} !== {g.win, g.fd}) begin
          n_fail++;
          $display("FAIL cont_win%0d: got %h/%b want %h/%b",
                   nw, w4, fd4, g.win, g.fd);
        end
        if (nw == 1) begin
          n_assert++;
          if (w4 !== pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
            n_fail++;
            $display("FAIL cont_first: got %h", w4);
          end
        end
      end else if (fd4 !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_fd_stray px%0d: got 1 want 0", i + 1);
      end
    end
    n_assert++;
    if (nw != 4 || nfd != 1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL cont_count: got %0d/%0d want 4/1", nw, nfd);
    end
  endtask

  task automatic test_gaps();
    exp_t          e, g;
    bit            ev, acc;
    int            sent = 0;
    int            nw = 0;
    logic [WV-1:0] prev;
    q.delete();
    mr = 0;
    mc = 0;
    for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
      acc = bit'($urandom_range(0, 1));
      ev = 1'b0;
      if (acc) begin
        model_pix(4, 4, DW'(sent + 1), ev, e);
        if (ev) q.push_back(e);
        d4 = DW'(sent + 1);
        sent++;
      end else begin
        d4 = DW'($urandom());
      end
      v4 = acc;
      prev = w4;
      @(posedge clk);
      #1;
      v4 = 1'b0;
      n_assert++;
      if (ov4 !== ev) begin
        n_fail++;
        $display("FAIL gap_valid cyc%0d: got %b want %b", cyc, ov4, ev);
      end
      if (!acc && w4 !== prev) begin
        n_fail++;
        $display("FAIL gap_hold cyc%0d: got %h want %h", cyc, w4, prev);
      end
      if (ov4 === 1'b1 && q.size() > 0) begin
        g = q.pop_front();
        nw++;
        n_assert++;
        if ({w4, fd4} !== {g.win, g.fd}) begin
          n_fail++;
          $display("FAIL gap_win%0d: got %h/%b want %h/%b",
                   nw, w4, fd4, g.win, g.fd);
        end
      end
    end
    n_assert++;
    if (sent != 16 || nw != 4 || q.size() != 0) begin
      n_fail++;
      $display("FAIL gap_count: sent %0d win %0d want 16/4", sent, nw);
    end
  endtask

  task automatic test_back_to_back();
    exp_t          e, g;
    bit            ev;
    int            nw = 0;
    int            nfd = 0;
    logic [DW-1:0] p;
    q.delete();
    mr = 0;
    mc = 0;
    for (int i = 0; i < 32; i++) begin
      p = (i < 16) ? DW'(i + 1) : DW'(101 + i - 16);
      model_pix(4, 4, p, ev, e);
      if (ev) q.push_back(e);
      d4 = p;
      v4 = 1'b1;
      @(posedge clk);
      #1;
      v4 = 1'b0;
      n_assert++;
      if (ov4 !== ev) begin
        n_fail++;
        $display("FAIL b2b_valid px%0d: got %b want %b", i, ov4, ev);
      end
      if (ov4 === 1'b1 && q.size() > 0) begin
        g = q.pop_front();
        nw++;
        if (fd4 === 1'b1) nfd++;
        n_assert++;
        if ({w4, fd4} !== {g.win, g.fd}) begin
          n_fail++;
          $display("FAIL b2b_win%0d: got %h/%b want %h/%b",
                   nw, w4, fd4, g.win, g.fd);
        end
        if (nw == 5) begin
          n_assert++;
          if (w4 !== pack9(101, 102, 103, 105, 106, 107, 109, 110, 111)) begin
            n_fail++;
            $display("FAIL b2b_frame2_first: got %h", w4);
          end
        end
      end
    end
    n_assert++;
    if (nw != 8 || nfd != 2 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d/%0d want 8/2", nw, nfd);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    bit   ev;
    int   nw = 0;
    for (int i = 0; i < 7; i++) begin
      d4 = DW'(i + 1);
      v4 = 1'b1;
      @(posedge clk);
      #1;
      v4 = 1'b0;
      n_assert++;
      if (ov4 !== 1'b0 || fd4 !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_partial px%0d: got %b/%b want 0/0",
                 i + 1, ov4, fd4);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    n_assert++;
    if ({w4, ov4, fd4} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: got %h want 0", {w4, ov4, fd4});
    end
    @(posedge clk);
    #1;
    n_assert++;
    if ({w4, ov4, fd4} !== '0) begin
      n_fail++;
      $display("FAIL rmid_held: got %h want 0", {w4, ov4, fd4});
    end
    rst = 1'b1;
    q.delete();
    mr = 0;
    mc = 0;
    for (int i = 0; i < 16; i++) begin
      model_pix(4, 4, DW'(i + 1), ev, e);
      if (ev) q.push_back(e);
      d4 = DW'(i + 1);
      v4 = 1'b1;
      @(posedge clk);
      #1;
      v4 = 1'b0;
      n_assert++;
      if (ov4 !== ev) begin
        n_fail++;
        $display("FAIL rmid_valid px%0d: got %b want %b", i + 1, ov4, ev);
      end
      if (ov4 === 1'b1 && q.size() > 0) begin
        g = q.pop_front();
        nw++;
        n_assert++;
        if ({w4, fd4} !== {g.win, g.fd}) begin
          n_fail++;
          $display("FAIL rmid_win%0d: got %h/%b want %h/%b",
                   nw, w4, fd4, g.win, g.fd);
        end
      end
    end
    n_assert++;
    if (nw != 4 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_count: got %0d want 4", nw);
    end
  endtask

  task automatic test_min_frame();
    int nw = 0;
    int nfd = 0;
    for (int i = 0; i < 9; i++) begin
      d3 = DW'(i + 1);
      v3 = 1'b1;
      @(posedge clk);
      #1;
      v3 = 1'b0;
      if (ov3 === 1'b1) nw++;
      if (fd3 === 1'b1) nfd++;
    end
    n_assert++;
    if ({ov3, fd3} !== 2'b11 || w3 !== pack9(1, 2, 3, 4, 5, 6, 7, 8, 9)) begin
      n_fail++;
      $display("FAIL min_win: got %h/%b%b want 1..9/11", w3, ov3, fd3);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (nw != 1 || nfd != 1 || ov3 !== 1'b0 || fd3 !== 1'b0) begin
      n_fail++;
      $display("FAIL min_count: got %0d/%0d want 1/1", nw, nfd);
    end
  endtask

  task automatic test_full_frame();
    exp_t e, g;
    bit   ev, acc;
    int   sent = 0;
    int   nw = 0;
    int   fd_at = -1;
    q.delete();
    mr = 0;
    mc = 0;
    for (int cyc = 0; cyc < 2000 && sent < 784; cyc++) begin
      acc = ($urandom_range(0, 3) != 0);
      ev = 1'b0;
      d28 = DW'($urandom());
      if (acc) begin
        model_pix(28, 28, d28, ev, e);
        if (ev) q.push_back(e);
        sent++;
      end
      v28 = acc;
      @(posedge clk);
      #1;
      v28 = 1'b0;
      if (ov28 !== ev) begin
        n_assert++;
        n_fail++;
        $display("FAIL full_valid cyc%0d: got %b want %b", cyc, ov28, ev);
      end
      if (fd28 === 1'b1) fd_at = nw + 1;
      if (ov28 === 1'b1 && q.size() > 0) begin
        g = q.pop_front();
        nw++;
        n_assert++;
        if ({w28, fd28} !== {g.win, g.fd}) begin
          n_fail++;
          $display("FAIL full_win%0d: got %h/%b want %h/%b",
                   nw, w28, fd28, g.win, g.fd);
        end
      end
    end
    n_assert++;
    if (sent != 784 || nw != 676 || fd_at != 676 || q.size() != 0) begin
      n_fail++;
      $display("FAIL full_count: sent %0d win %0d fd@%0d want 784/676/676",
               sent, nw, fd_at);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    repeat (3) @(posedge clk);
    #1;
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_min_frame();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
